// File: rtl/div_43x17.sv
// Restoring divider: 43-bit dividend / 17-bit divisor -> 26-bit quotient, 17-bit remainder.
// Optional macro DIV_RADIX4_EN retires two quotient bits per cycle instead of one.
module div_43x17 #(
  parameter int X_W = 26,
  parameter int Y_W = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [X_W+Y_W-1:0]   dividend,
  input  logic [Y_W-1:0]       divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [X_W-1:0]       quotient,
  output logic [Y_W-1:0]       remainder,
  output logic                 div_by_zero,
  output logic                 overflow,
  output logic [1:0]           o_dbg_state
);

  localparam int P_W = X_W + Y_W;
`ifdef DIV_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int CNT_W = $clog2(X_W);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds data stable while valid is high and ready is low.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_next;
  logic [Y_W-1:0]   r_rem, r_dvs;
  logic [X_W-1:0]   r_lo, r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dbz, r_ovf;

  logic             w_accept, w_is_zero, w_is_ovf, w_last;
  logic [Y_W-1:0]   w_src_r, w_src_d, w_new_rem;
  logic [X_W-1:0]   w_src_lo, w_new_lo, w_new_q;
  logic [Y_W:0]     w_s1;
  logic [STEP-1:0]  w_qbits;

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [Y_W:0] rstep(input logic [Y_W-1:0] r, input logic b,
                                         input logic [Y_W-1:0] d);
    logic [Y_W:0] t;
    t = {r, b};
    if (t >= {1'b0, d}) begin
      t = t - {1'b0, d};
      return {1'b1, t[Y_W-1:0]};
    end
    return {1'b0, t[Y_W-1:0]};
  endfunction

  assign w_accept  = in_valid && in_ready;
  assign w_is_zero = (divisor == '0);
  assign w_is_ovf  = (dividend[P_W-1:X_W] >= divisor);
  assign w_last    = (r_cnt == CNT_W'(STEP - 1));

  // The accept cycle already performs the first step(s) straight from the input operands.
  assign w_src_r  = (r_state == S_CALC) ? r_rem : dividend[P_W-1:X_W];
  assign w_src_lo = (r_state == S_CALC) ? r_lo  : dividend[X_W-1:0];
  assign w_src_d  = (r_state == S_CALC) ? r_dvs : divisor;
  assign w_s1     = rstep(w_src_r, w_src_lo[X_W-1], w_src_d);

`ifdef DIV_RADIX4_EN
  logic [Y_W:0] w_s2;
  assign w_s2      = rstep(w_s1[Y_W-1:0], w_src_lo[X_W-2], w_src_d);
  assign w_new_rem = w_s2[Y_W-1:0];
  assign w_qbits   = {w_s1[Y_W], w_s2[Y_W]};
`else
  assign w_new_rem = w_s1[Y_W-1:0];
  assign w_qbits   = w_s1[Y_W];
`endif

  assign w_new_lo = w_src_lo << STEP;
  assign w_new_q  = (r_state == S_CALC) ? {r_q[X_W-STEP-1:0], w_qbits}
                                        : {{(X_W-STEP){1'b0}}, w_qbits};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = (w_is_zero || w_is_ovf) ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == S_IDLE);
    out_valid   = (r_state == S_DONE);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
      r_dvs <= '0;
      r_lo  <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && w_accept) begin
      r_dvs <= divisor;
      r_dbz <= w_is_zero;
      r_ovf <= !w_is_zero && w_is_ovf;
      if (w_is_zero || w_is_ovf) begin
        r_q   <= '1;
        r_rem <= '0;
        r_lo  <= '0;
        r_cnt <= '0;
      end else begin
        r_q   <= w_new_q;
        r_rem <= w_new_rem;
        r_lo  <= w_new_lo;
        r_cnt <= CNT_W'(X_W - 1 - STEP);
      end
    end else if (r_state == S_CALC) begin
      r_q   <= w_new_q;
      r_rem <= w_new_rem;
      r_lo  <= w_new_lo;
      r_cnt <= r_cnt - CNT_W'(STEP);
    end
  end

  assign quotient    = r_q;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_div_43x17.sv
// Directed + random bench for div_43x17 with an expected-result queue and latency checks.
module tb_div_43x17;
  localparam int X_W = 26;
  localparam int Y_W = 17;
  localparam int P_W = X_W + Y_W;
  localparam int E_W = 2 + X_W + Y_W;
`ifdef DIV_RADIX4_EN
  localparam int NORM_LAT = X_W / 2;
`else
  localparam int NORM_LAT = X_W;
`endif

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, out_valid, out_ready;
  logic [P_W-1:0] dividend;
  logic [Y_W-1:0] divisor, remainder;
  logic [X_W-1:0] quotient;
  logic           div_by_zero, overflow;
  logic [1:0]     dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [E_W-1:0] exp_q[$];
  int             lat_q[$];

  div_43x17 dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .overflow(overflow), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [E_W-1:0] model(input logic [P_W-1:0] dvd, input logic [Y_W-1:0] dvs);
    logic [63:0] q, r;
    if (dvs == '0) return {2'b10, {X_W{1'b1}}, {Y_W{1'b0}}};
    if ((64'(dvd) >> X_W) >= 64'(dvs)) return {2'b01, {X_W{1'b1}}, {Y_W{1'b0}}};
    q = 64'(dvd) / 64'(dvs);
    r = 64'(dvd) % 64'(dvs);
    return {2'b00, q[X_W-1:0], r[Y_W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"}, 64'({div_by_zero, overflow, quotient, remainder}), 64'd0);
  endtask

  // Drives one operation, then collects and scores the result; hold = cycles of out_ready=0.
  task automatic run_op(input string tag, input logic [P_W-1:0] dvd, input logic [Y_W-1:0] dvs,
                        input int hold);
    logic [E_W-1:0] expv;
    int lat, exp_lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    out_ready = (hold == 0);
    exp_q.push_back(model(dvd, dvs));
    lat_q.push_back((dvs == '0 || (64'(dvd) >> X_W) >= 64'(dvs)) ? 1 : NORM_LAT);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = Y_W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    expv    = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, 64'({div_by_zero, overflow, quotient, remainder}), 64'(expv));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = {$urandom, $urandom};
      divisor  = Y_W'($urandom_range(1, 50));
      @(negedge clk);
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_result"}, 64'({div_by_zero, overflow, quotient, remainder}), 64'(expv));
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_post_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [Y_W-1:0] rdvs, rhi;
    logic [X_W-1:0] rlo;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    run_op("basic",    43'd1234500, 17'd100, 0);
    run_op("max_ops",  43'h7FF_FBFF_FFFF, 17'h1FFFF, 0);
    run_op("ovf_5",    43'd5 << 26, 17'd5, 0);
    run_op("ovf_div1", 43'h7FF_FFFF_FFFF, 17'd1, 0);
    run_op("dbz_77",   43'd77, 17'd0, 0);
    run_op("dbz_prio", 43'h7FF_FFFF_FFFF, 17'd0, 0);
    run_op("edge_hi",  {17'd4, 26'h3FF_FFFF}, 17'd5, 0);
    run_op("ovf_eq",   {17'd5, 26'd0}, 17'd5, 0);
    run_op("bp_1000",  43'd1000, 17'd7, 10);

    // Reset in the middle of a calculation discards the result.
    @(negedge clk);
    in_valid = 1'b1; dividend = 43'd1000000; divisor = 17'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_calc_busy", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("post_reset");
    run_op("after_rst", 43'd99, 17'd10, 0);

    for (int k = 0; k < 8; k++) begin
      rdvs = Y_W'($urandom_range(1, (1 << Y_W) - 1));
      rhi  = Y_W'($urandom_range(0, int'(rdvs) - 1));
      rlo  = X_W'($urandom);
      run_op("rand", {rhi, rlo}, rdvs, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
